// File: rtl/trace_monitor_pkg.sv
// Shared definitions for the trace monitor slice.
// Contents: the controller state encoding, the dump_kind constants and the
// dump-beat width helper.
package trace_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DUMP_RF = 3'd2,
    ST_DUMP_TR = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic DUMP_KIND_REG   = 1'b0;
  localparam logic DUMP_KIND_TRACE = 1'b1;

  // A dump beat carries {pc, instr}; register beats are zero-extended to the same width.
  function automatic int unsigned dump_beat_w(input int unsigned addr_w,
                                              input int unsigned instr_w);
    return addr_w + instr_w;
  endfunction

endpackage

// File: rtl/trace_ring_buf.sv
// Circular trace buffer. When it is full, a push overwrites the oldest entry.
// Ports:
//   clk, rst      clock and synchronous active-low reset
//   clr           synchronous clear (empties the buffer)
//   push, wdata   write one entry
//   pop           drop the oldest entry (ignored when empty)
//   rdata         oldest entry (combinational read)
//   empty         buffer holds no entries
//   overwrite     current push discards the oldest entry
module trace_ring_buf #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             overwrite
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             full;
  logic             do_pop;

  assign full      = (cnt == (PTR_W+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign do_pop    = pop && !empty;
  assign overwrite = push && full && !do_pop;
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // An overwrite retires the oldest entry exactly like a pop.
      if (do_pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
      if (push && !full && !do_pop) cnt <= cnt + 1'b1;
      else if (do_pop && !push)     cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/trace_monitor.sv
// Run-control and trace monitor for a CPU under test.
// Lets the CPU run for up to MAX_CYCLES cycles or until a PC breakpoint
// commits. The CPU is then frozen and the monitor streams out the register
// file, followed by the retired-instruction trace (oldest first).
// Build option: TRACE_MONITOR_TRACE_BUF_EN includes the trace buffer and the
// trace dump. Without it the dump holds registers only, and trace_ovf is 0.
// Ports:
//   clk, rst                           clock and synchronous active-low reset
//   start                              begin a run (only in IDLE or DONE)
//   bp_en, bp_addr                     PC breakpoint
//   commit_valid/pc/instr              retired instruction
//   cpu_stall                          freezes the CPU in every state but RUN
//   rf_raddr, rf_rdata                 combinational register-file read port
//   dump_valid/ready/kind/idx/data     registered valid/ready dump stream
//   cycle_count, trace_ovf, done       run status
module trace_monitor
  import trace_monitor_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       bp_en,
  input  logic [ADDR_W-1:0]                          bp_addr,
  input  logic                                       commit_valid,
  input  logic [ADDR_W-1:0]                          commit_pc,
  input  logic [INSTR_W-1:0]                         commit_instr,
  output logic                                       cpu_stall,
  output logic [4:0]                                 rf_raddr,
  input  logic [31:0]                                rf_rdata,
  output logic                                       dump_valid,
  input  logic                                       dump_ready,
  output logic                                       dump_kind,
  output logic [7:0]                                 dump_idx,
  output logic [dump_beat_w(ADDR_W, INSTR_W)-1:0]    dump_data,
  output logic [15:0]                                cycle_count,
  output logic                                       trace_ovf,
  output logic                                       done
);

  localparam int unsigned BEAT_W  = dump_beat_w(ADDR_W, INSTR_W);
  localparam logic [15:0] MAX_CNT = 16'(MAX_CYCLES);
  localparam logic [7:0]  RF_END  = 8'(NUM_REGS);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         idx;          // next item to fetch in the current dump phase
  logic [15:0]        cnt_inc;
  logic               bp_hit;
  logic               can_load;
  logic               rf_more;
  logic               rf_load;
  logic               tr_load;
  logic               buf_push;
  logic               buf_pop;
  logic               run_clear;
  logic [BEAT_W-1:0]  buf_rdata;
  logic               buf_empty;

  assign cnt_inc  = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
  assign bp_hit   = commit_valid && bp_en && (commit_pc == bp_addr);
  // The output register may take a new beat once it is empty or is being accepted.
  assign can_load = !dump_valid || dump_ready;
  assign rf_more  = (idx != RF_END);
  assign rf_raddr = idx[4:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Dump phases exit only when the last beat has drained from the output register.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (start) state_nxt = ST_RUN;
      ST_RUN:     if (cnt_inc == MAX_CNT || bp_hit) state_nxt = ST_DUMP_RF;
      ST_DUMP_RF: if (can_load && !rf_more) state_nxt = buf_empty ? ST_DONE : ST_DUMP_TR;
      ST_DUMP_TR: if (can_load && buf_empty) state_nxt = ST_DONE;
      ST_DONE:    if (start) state_nxt = ST_RUN;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = (state != ST_RUN);
    done      = (state == ST_DONE);
    run_clear = start && (state == ST_IDLE || state == ST_DONE);
    buf_push  = (state == ST_RUN) && commit_valid;
    rf_load   = (state == ST_DUMP_RF) && can_load && rf_more;
    tr_load   = (state == ST_DUMP_TR) && can_load && !buf_empty;
    buf_pop   = tr_load;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_count <= '0;
      idx         <= '0;
      dump_valid  <= 1'b0;
      dump_kind   <= DUMP_KIND_REG;
      dump_idx    <= '0;
      dump_data   <= '0;
    end else begin
      if (run_clear)             cycle_count <= '0;
      else if (state == ST_RUN)  cycle_count <= cnt_inc;

      // Every phase change restarts numbering; loads never coincide with a phase change.
      if (state_nxt != state)    idx <= '0;
      else if (rf_load || tr_load) idx <= idx + 8'd1;

      if (rf_load || tr_load) begin
        dump_valid <= 1'b1;
        dump_idx   <= idx;
        dump_kind  <= tr_load ? DUMP_KIND_TRACE : DUMP_KIND_REG;
        if (tr_load)         dump_data <= buf_rdata;
        else if (idx == '0)  dump_data <= '0;
        else                 dump_data <= BEAT_W'(rf_rdata);
      end else if (dump_ready) begin
        dump_valid <= 1'b0;
      end
    end
  end

`ifdef TRACE_MONITOR_TRACE_BUF_EN
  logic buf_overwrite;
  logic ovf_q;

  trace_ring_buf #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (run_clear),
    .push      (buf_push),
    .wdata     ({commit_pc, commit_instr}),
    .pop       (buf_pop),
    .rdata     (buf_rdata),
    .empty     (buf_empty),
    .overwrite (buf_overwrite)
  );

  always_ff @(posedge clk) begin
    if (!rst || run_clear) ovf_q <= 1'b0;
    else if (buf_overwrite) ovf_q <= 1'b1;
  end

  assign trace_ovf = ovf_q;
`else
  // No storage: a permanently empty buffer routes DUMP_RF straight to DONE.
  logic unused_nobuf;
  assign buf_rdata    = '0;
  assign buf_empty    = 1'b1;
  assign trace_ovf    = 1'b0;
  assign unused_nobuf = ^{buf_push, buf_pop, commit_instr, 32'(DEPTH)};
`endif

endmodule

// File: doc/trace_monitor.md
TRACE_MONITOR -- requirements
Module: trace_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, 32, PC width.
REQ-002 SHALL have parameter INSTR_W, 32, instruction width.
REQ-003 SHALL have parameter DEPTH, 16, trace buffer entries (power of two, >=2).
REQ-004 SHALL have parameter MAX_CYCLES, 40, run-cycle limit (1..65535).
REQ-005 SHALL have parameter NUM_REGS, 32, register-file entries dumped (power of two, <=32).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port start  input  1  pulse to begin a run.
REQ-009 SHALL have ports bp_en  input  1 and bp_addr  input  ADDR_W  PC breakpoint.
REQ-010 SHALL have ports commit_valid  input  1, commit_pc  input  ADDR_W, commit_instr  input  INSTR_W  retired instruction.
REQ-011 SHALL have port cpu_stall  output  1  freezes the CPU.
REQ-012 SHALL have ports rf_raddr  output  5 and rf_rdata  input  32  combinational-read register port.
REQ-013 SHALL have ports dump_valid  output  1, dump_ready  input  1, dump_kind  output  1 (0 = reg, 1 = trace), dump_idx  output  8, dump_data  output  ADDR_W+INSTR_W.
REQ-014 SHALL have ports cycle_count  output  16, trace_ovf  output  1, done  output  1.

Function
REQ-015 SHALL implement states IDLE, RUN, DUMP_RF, DUMP_TR, DONE.
REQ-016 SHALL go IDLE->RUN on start; start SHALL be ignored outside IDLE and DONE; start in DONE SHALL clear counters and buffer, then enter RUN.
REQ-017 SHALL increment cycle_count on every RUN cycle, saturating at 16'hFFFF.
REQ-018 SHALL push {commit_pc, commit_instr} into a circular buffer on each RUN cycle with commit_valid; when full, SHALL overwrite the oldest entry and set trace_ovf sticky until the next start.
REQ-019 SHALL leave RUN for DUMP_RF on the cycle after cycle_count reaches MAX_CYCLES, or on the cycle after a commit whose commit_pc equals bp_addr while bp_en=1; that commit SHALL be recorded; simultaneous conditions SHALL act as one halt.
REQ-020 SHALL drive cpu_stall=1 in every state except RUN.
REQ-021 SHALL, in DUMP_RF, emit registers 0..NUM_REGS-1 in order, dump_kind=0, dump_idx=register number, dump_data={zeros, rf_rdata}; register 0 SHALL emit 0 regardless of rf_rdata.
REQ-022 SHALL, in DUMP_TR, emit buffered entries oldest first, dump_kind=1, dump_idx=0..count-1; an empty buffer SHALL go directly to DONE.
REQ-023 SHALL register dump outputs; a beat transfers when dump_valid and dump_ready are both 1; while dump_valid=1 and dump_ready=0, dump_kind/idx/data SHALL hold stable; back-to-back beats SHALL sustain one per cycle.
REQ-024 SHALL assert done=1 only in DONE; cycle_count and trace_ovf SHALL hold their final values in DUMP_RF, DUMP_TR and DONE.

Reset
REQ-025 SHALL, when rst=0 at a clock edge, enter IDLE with cycle_count=0, trace_ovf=0, done=0, dump_valid=0, dump_kind=0, dump_idx=0, dump_data=0, rf_raddr=0, cpu_stall=1, buffer empty, regardless of current state (including mid-dump).

Configuration
REQ-026 SHALL, with TRACE_MONITOR_TRACE_BUF_EN defined, include the trace buffer and DUMP_TR.
REQ-027 SHALL, without TRACE_MONITOR_TRACE_BUF_EN, omit the buffer storage, go DUMP_RF->DONE, and tie trace_ovf=0; all other behaviour is unchanged.

Structure
REQ-028 SHALL take the state encoding, DUMP_KIND_REG/DUMP_KIND_TRACE constants and the dump-beat width function from shared package trace_monitor_pkg.
REQ-029 SHALL place the circular buffer (write pointer, read pointer, count, overwrite) in sub-module trace_ring_buf.

Verification
REQ-030 SHALL test: MAX_CYCLES=40, commit every cycle, PCs 0x00,0x04,... -> halt after 40 RUN cycles, cycle_count=40, trace_ovf=1, trace dump idx 0..15 carries PCs 0x60..0x9C.
REQ-031 SHALL test: bp_en=1, bp_addr=0x14 -> last trace entry PC 0x14, cpu_stall=1 the following cycle, cycle_count=6.
REQ-032 SHALL test: rf_rdata=0xDEADBEEF for all addresses -> reg beat 0 data=0, beats 1..31 data=0xDEADBEEF.
REQ-033 SHALL test: dump_ready low for 3 cycles mid-dump -> beat held stable, no beat lost or duplicated; total 32+16 beats.
REQ-034 SHALL test: rst=0 during DUMP_RF at beat 10 -> next cycle IDLE, all outputs at reset values; a new start yields a full correct run.
REQ-035 SHALL test: build without TRACE_MONITOR_TRACE_BUF_EN -> exactly 32 beats, all dump_kind=0, then done=1.
